// File: rtl/ps2_ascii_receiver.sv
// PS/2 keyboard receiver: synchronises the raw pins, deframes set-2 scan codes,
// turns make codes into ASCII and queues them in a show-ahead FIFO for the core.
module ps2_ascii_receiver #(
  parameter int FIFO_AW        = 3,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_dat,
  input  logic               ascii_rd,
  output logic               ascii_valid,
  output logic [7:0]         ascii_data,
  output logic [FIFO_AW:0]   fifo_count,
  output logic               frame_err,
  output logic               overflow
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  logic clk_s1_q, clk_s1_d, clk_s2_q, clk_s2_d, clk_prev_q, clk_prev_d;
  logic dat_s1_q, dat_s1_d, dat_s2_q, dat_s2_d, dat_q, dat_d;
  logic fall_q, fall_d;

  state_t          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            parity_ok_q, parity_ok_d;
  logic            byte_done_q, byte_done_d;
  logic            frame_err_q, frame_err_d;
  logic            timeout;

  logic            brk_q, brk_d, ext_q, ext_d, shift_q, shift_d;
  logic            push_q, push_d;
  logic [7:0]      push_char_q, push_char_d;
  logic            lut_hit, is_shift_code;
  logic [7:0]      lut_char;

  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               fifo_empty, fifo_full, do_push, do_pop;

  // Data is delayed alongside the edge register so it is sampled with the edge.
  always_comb begin
    clk_s1_d   = ps2_clk;
    clk_s2_d   = clk_s1_q;
    clk_prev_d = clk_s2_q;
    fall_d     = clk_prev_q & ~clk_s2_q;
    dat_s1_d   = ps2_dat;
    dat_s2_d   = dat_s1_q;
    dat_d      = dat_s2_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
      dat_q      <= 1'b1;
      fall_q     <= 1'b0;
    end else begin
      clk_s1_q   <= clk_s1_d;
      clk_s2_q   <= clk_s2_d;
      clk_prev_q <= clk_prev_d;
      dat_s1_q   <= dat_s1_d;
      dat_s2_q   <= dat_s2_d;
      dat_q      <= dat_d;
      fall_q     <= fall_d;
    end
  end

  assign timeout = (state_q != S_IDLE) && !fall_q && (timer_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      parity_ok_q <= 1'b0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      parity_ok_q <= parity_ok_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (fall_q) begin
      unique case (state_q)
        S_IDLE:   if (!dat_q) state_d = S_DATA;
        S_DATA:   if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    byte_done_d = 1'b0;
    frame_err_d = timeout;
    if (fall_q && state_q == S_STOP) begin
      if (dat_q && parity_ok_q) byte_done_d = 1'b1;
      else                      frame_err_d = 1'b1;
    end
  end

  // The timer only runs mid-frame and restarts on every falling edge.
  always_comb begin
    timer_d     = timer_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    parity_ok_d = parity_ok_q;
    if (fall_q || state_q == S_IDLE)          timer_d = '0;
    else if (timer_q != TW'(TIMEOUT_CYCLES - 1)) timer_d = timer_q + TW'(1);
    if (fall_q) begin
      unique case (state_q)
        S_IDLE: bit_cnt_d = 3'd0;
        S_DATA: begin
          shreg_d   = {dat_q, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        S_PARITY: parity_ok_d = ^{shreg_q, dat_q};
        default: ;
      endcase
    end
  end

  function automatic logic [8:0] lookup(input logic [7:0] code, input logic upper);
    logic [4:0] idx;
    logic       letter;
    logic [8:0] r;
    idx    = '0;
    letter = 1'b1;
    r      = '0;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      r = {1'b1, (upper ? 8'h41 : 8'h61) + {3'b000, idx}};
    end else begin
      case (code)
        8'h45: r = {1'b1, 8'h30};  8'h16: r = {1'b1, 8'h31};
        8'h1E: r = {1'b1, 8'h32};  8'h26: r = {1'b1, 8'h33};
        8'h25: r = {1'b1, 8'h34};  8'h2E: r = {1'b1, 8'h35};
        8'h36: r = {1'b1, 8'h36};  8'h3D: r = {1'b1, 8'h37};
        8'h3E: r = {1'b1, 8'h38};  8'h46: r = {1'b1, 8'h39};
        8'h29: r = {1'b1, 8'h20};  8'h5A: r = {1'b1, 8'h0D};
        8'h66: r = {1'b1, 8'h08};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  assign {lut_hit, lut_char} = lookup(shreg_q, shift_q);
  assign is_shift_code       = (shreg_q == 8'h12) || (shreg_q == 8'h59);

  // Prefix bytes only arm brk/ext; the following code consumes and clears them.
  always_comb begin
    brk_d       = brk_q;
    ext_d       = ext_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    push_char_d = push_char_q;
    if (byte_done_q) begin
      if (shreg_q == 8'hF0) begin
        brk_d = 1'b1;
      end else if (shreg_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (brk_q) begin
        if (is_shift_code) shift_d = 1'b0;
        brk_d = 1'b0;
        ext_d = 1'b0;
      end else begin
        if (is_shift_code) begin
          shift_d = 1'b1;
        end else if (!ext_q && lut_hit) begin
          push_d      = 1'b1;
          push_char_d = lut_char;
        end
        ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      brk_q       <= 1'b0;
      ext_q       <= 1'b0;
      shift_q     <= 1'b0;
      push_q      <= 1'b0;
      push_char_q <= '0;
    end else begin
      brk_q       <= brk_d;
      ext_q       <= ext_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      push_char_q <= push_char_d;
    end
  end

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (FIFO_AW + 1)'(DEPTH));
  assign do_pop     = ascii_rd && !fifo_empty;
  assign do_push    = push_q && (!fifo_full || do_pop);

  // When full, a simultaneous pop frees the head slot, which is where wp points.
  always_comb begin
    wp_d       = wp_q + FIFO_AW'(do_push);
    rp_d       = rp_q + FIFO_AW'(do_pop);
    count_d    = count_q + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
    overflow_d = overflow_q | (push_q && fifo_full && !do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wp_q] <= push_char_q;
  end

  assign ascii_valid = !fifo_empty;
  assign ascii_data  = fifo_empty ? 8'h00 : mem_q[rp_q];
  assign fifo_count  = count_q;
  assign frame_err   = frame_err_q;
  assign overflow    = overflow_q;

endmodule
